// File: rtl/arb_xfer_ctrl_if.sv
// Handshake bundle between the arbiter/clients, the transfer controller and the shared output channel.
// master = the transfer controller, slave = the surrounding clients, arbiter and downstream sink.
interface arb_xfer_ctrl_if #(
    parameter int DATA_W = 8
);
    logic [2:0]          req;
    logic [2:0]          grant;
    logic [3*DATA_W-1:0] data_in;
    logic [2:0]          src_ready;
    logic [2:0]          done;
    logic                out_valid;
    logic [DATA_W-1:0]   out_data;
    logic [1:0]          out_src;
    logic                out_last;
    logic                out_ready;

    modport master (
        input  req, grant, data_in, out_ready,
        output src_ready, done, out_valid, out_data, out_src, out_last
    );

    modport slave (
        output req, grant, data_in, out_ready,
        input  src_ready, done, out_valid, out_data, out_src, out_last
    );
endinterface

// File: rtl/arb_xfer_ctrl.sv
// Moves a fixed-length burst from the granted client onto one shared valid/ready channel.
// Optional macro GRANT_ONEHOT_CHK_EN adds a sticky grant_err flag and refuses multi-hot grants.
module arb_xfer_ctrl #(
    parameter int DATA_W    = 8,
    parameter int BURST_LEN = 4,
    parameter int TIMEOUT   = 16
) (
    input  logic            clk,
    input  logic            reset,
    arb_xfer_ctrl_if.master bus,
    output logic            busy,
    output logic            timeout_err
`ifdef GRANT_ONEHOT_CHK_EN
    ,
    output logic            grant_err
`endif
);
    localparam int CNT_MAX = (BURST_LEN > TIMEOUT) ? BURST_LEN : TIMEOUT;
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;

    localparam logic [CNT_W-1:0] LAST_BEAT   = CNT_W'(BURST_LEN - 1);
    localparam logic [CNT_W-1:0] STALL_LIMIT = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [1:0]       owner_q, owner_d;
    logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic             timeout_err_q, timeout_err_d;

    logic [2:0]        claim;
    logic              capture_ok;
    logic [DATA_W-1:0] owner_data;

    logic              out_valid_c;
    logic              out_last_c;
    logic [1:0]        out_src_c;
    logic [DATA_W-1:0] out_data_c;
    logic [2:0]        src_ready_c;
    logic [2:0]        done_c;

    function automatic logic [1:0] lowest_index(input logic [2:0] v);
        if (v[0])      return 2'd0;
        else if (v[1]) return 2'd1;
        else           return 2'd2;
    endfunction

    assign claim = bus.grant & bus.req;

`ifdef GRANT_ONEHOT_CHK_EN
    logic grant_multi;
    logic grant_err_q, grant_err_d;

    assign grant_multi = (bus.grant & (bus.grant - 3'd1)) != 3'd0;
    assign capture_ok  = !grant_multi;
    assign grant_err_d = grant_err_q | grant_multi;
`else
    // Multi-hot grants fall through to lowest-index resolution of grant & req.
    assign capture_ok = 1'b1;
`endif

    always_comb begin
        owner_data = bus.data_in[0 +: DATA_W];
        if (owner_q == 2'd1)      owner_data = bus.data_in[DATA_W +: DATA_W];
        else if (owner_q == 2'd2) owner_data = bus.data_in[2*DATA_W +: DATA_W];
    end

    always_comb begin
        // NOTE: every signal written here gets a default first, so no branch can leave one holding state (no latch).
        state_d       = state_q;
        owner_d       = owner_q;
        beat_cnt_d    = beat_cnt_q;
        stall_cnt_d   = stall_cnt_q;
        timeout_err_d = timeout_err_q;
        out_valid_c   = 1'b0;
        out_last_c    = 1'b0;
        out_src_c     = 2'd0;
        out_data_c    = '0;
        src_ready_c   = 3'b000;
        done_c        = 3'b000;

        case (state_q)
            IDLE: begin
                beat_cnt_d  = '0;
                stall_cnt_d = '0;
                if (claim != 3'b000 && capture_ok) begin
                    owner_d = lowest_index(claim);
                    state_d = XFER;
                end
            end

            XFER: begin
                out_src_c  = owner_q;
                out_data_c = owner_data;
                if (!bus.req[owner_q]) begin
                    // Owner withdrew: abandon the burst silently, no beat this cycle.
                    state_d = IDLE;
                end else begin
                    out_valid_c = 1'b1;
                    out_last_c  = (beat_cnt_q == LAST_BEAT);
                    if (bus.out_ready) begin
                        src_ready_c = 3'b001 << owner_q;
                        beat_cnt_d  = beat_cnt_q + CNT_ONE;
                        stall_cnt_d = '0;
                        if (beat_cnt_q == LAST_BEAT) state_d = DONE;
                    end else if (stall_cnt_q == STALL_LIMIT) begin
                        timeout_err_d = 1'b1;
                        state_d       = DONE;
                    end else begin
                        stall_cnt_d = stall_cnt_q + CNT_ONE;
                    end
                end
            end

            DONE: begin
                done_c  = 3'b001 << owner_q;
                state_d = IDLE;
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples the pre-edge value of the others.
        if (reset) begin
            state_q       <= IDLE;
            owner_q       <= 2'd0;
            beat_cnt_q    <= '0;
            stall_cnt_q   <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            owner_q       <= owner_d;
            beat_cnt_q    <= beat_cnt_d;
            stall_cnt_q   <= stall_cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end

`ifdef GRANT_ONEHOT_CHK_EN
    always_ff @(posedge clk) begin
        if (reset) grant_err_q <= 1'b0;
        else       grant_err_q <= grant_err_d;
    end

    assign grant_err = grant_err_q & ~reset;
`endif

    // Outputs are forced quiet while reset is held, so a mid-burst reset stops beats at once.
    assign bus.out_valid = out_valid_c & ~reset;
    assign bus.out_last  = out_last_c & ~reset;
    assign bus.out_src   = reset ? 2'd0 : out_src_c;
    assign bus.out_data  = reset ? '0 : out_data_c;
    assign bus.src_ready = reset ? 3'b000 : src_ready_c;
    assign bus.done      = reset ? 3'b000 : done_c;
    assign busy          = (state_q != IDLE) & ~reset;
    assign timeout_err   = timeout_err_q & ~reset;

    a_done_onehot0: assert property (@(posedge clk) $onehot0(bus.done));
    a_srdy_onehot0: assert property (@(posedge clk) $onehot0(bus.src_ready));
    a_last_valid:   assert property (@(posedge clk) bus.out_last |-> bus.out_valid);
endmodule

// File: tb/tb_arb_xfer_ctrl.sv
// Self-checking bench for arb_xfer_ctrl: directed vector table, corner-case sequences and a
// randomized run checked every cycle against a transaction-level reference model.
module tb_arb_xfer_ctrl;
    localparam int DATA_W    = 8;
    localparam int BURST_LEN = 4;
    localparam int TIMEOUT   = 16;

    logic clk = 1'b0;
    logic reset;
    logic busy;
    logic timeout_err;
`ifdef GRANT_ONEHOT_CHK_EN
    logic grant_err;
`endif

    arb_xfer_ctrl_if #(.DATA_W(DATA_W)) bus ();

    arb_xfer_ctrl #(
        .DATA_W   (DATA_W),
        .BURST_LEN(BURST_LEN),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .busy       (busy),
        .timeout_err(timeout_err)
`ifdef GRANT_ONEHOT_CHK_EN
        ,
        .grant_err  (grant_err)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    localparam logic [23:0] DATA_WORD = {8'h3C, 8'hA5, 8'h5A};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s (cycle %0d): got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    // Reference model: tracks the transfer in progress as plain counts.
    bit m_active;
    bit m_done_due;
    int m_owner;
    int m_sent;
    int m_stalled;
    bit m_terr;
    bit m_gerr;

    function automatic logic [31:0] pack_dut();
        logic gerr;
`ifdef GRANT_ONEHOT_CHK_EN
        gerr = grant_err;
`else
        gerr = 1'b0;
`endif
        return {11'd0, gerr, busy, timeout_err, bus.done, bus.src_ready,
                bus.out_valid, bus.out_last, bus.out_src, bus.out_data};
    endfunction

    task automatic model_eval(input logic rst, input logic [2:0] r, input logic [2:0] g,
                              input logic [23:0] d, input logic rdy, output logic [31:0] exp);
        logic [2:0] e_done, e_srdy;
        logic       e_valid, e_last, e_busy;
        logic [1:0] e_src;
        logic [7:0] e_data;
        logic       e_terr, e_gerr;
        logic [2:0] claim;
        bit         multi;
        e_done = 3'b000; e_srdy = 3'b000; e_valid = 1'b0; e_last = 1'b0; e_busy = 1'b0;
        e_src = 2'd0; e_data = 8'h00;
        e_terr = m_terr; e_gerr = m_gerr;
        multi = ($countones(g) > 1);
        if (rst) begin
            m_active = 0; m_done_due = 0; m_owner = 0; m_sent = 0; m_stalled = 0;
            m_terr = 0; m_gerr = 0;
            exp = 32'd0;
            return;
        end
        if (m_done_due) begin
            e_busy = 1'b1;
            e_done[m_owner] = 1'b1;
            m_done_due = 0;
        end else if (m_active) begin
            e_busy = 1'b1;
            e_src  = 2'(m_owner);
            e_data = d[m_owner*8 +: 8];
            if (!r[m_owner]) begin
                m_active = 0;
            end else begin
                e_valid = 1'b1;
                e_last  = (m_sent == BURST_LEN - 1);
                if (rdy) begin
                    e_srdy[m_owner] = 1'b1;
                    m_sent++;
                    m_stalled = 0;
                    if (m_sent == BURST_LEN) begin m_active = 0; m_done_due = 1; end
                end else begin
                    m_stalled++;
                    if (m_stalled == TIMEOUT) begin m_terr = 1; m_active = 0; m_done_due = 1; end
                end
            end
        end else begin
            claim = g & r;
`ifdef GRANT_ONEHOT_CHK_EN
            if (multi) claim = 3'b000;
`endif
            for (int i = 2; i >= 0; i--) begin
                if (claim[i]) begin
                    m_owner = i; m_active = 1; m_sent = 0; m_stalled = 0;
                end
            end
        end
`ifdef GRANT_ONEHOT_CHK_EN
        if (multi) m_gerr = 1;
`endif
        exp = {11'd0, e_gerr, e_busy, e_terr, e_done, e_srdy, e_valid, e_last, e_src, e_data};
    endtask

    // One clock: drive inputs on the falling edge, compare against the model 1 time unit later.
    task automatic step(input logic rst, input logic [2:0] r, input logic [2:0] g,
                        input logic [23:0] d, input logic rdy);
        logic [31:0] exp;
        @(negedge clk);
        reset         = rst;
        bus.req       = r;
        bus.grant     = g;
        bus.data_in   = d;
        bus.out_ready = rdy;
        #1;
        model_eval(rst, r, g, d, rdy, exp);
        check("model", pack_dut(), exp);
        cyc++;
    endtask

    // Grant one client at cycle N, then follow the burst with a per-cycle out_ready map.
    task automatic run_burst(input int client, input logic [63:0] ready_map,
                             output int beats, output int last_beat, output int done_at,
                             output int done_cnt);
        logic [2:0] oh;
        oh = 3'b001 << client;
        beats = 0; last_beat = -1; done_at = -1; done_cnt = 0;
        step(1'b0, oh, oh, DATA_WORD, 1'b1);
        for (int t = 1; t <= 60; t++) begin
            step(1'b0, (done_at >= 0) ? 3'b000 : oh, 3'b000, DATA_WORD, ready_map[t-1]);
            if (bus.src_ready[client]) begin
                beats++;
                if (bus.out_last) last_beat = beats;
            end
            if (bus.done != 3'b000) begin
                done_cnt++;
                if (done_at < 0) done_at = t;
            end
            if (!busy && t > 1) break;
        end
    endtask

    typedef struct {
        logic [2:0] req;
        logic [2:0] grant;
        logic       rdy;
        logic       exp_valid;
        logic       exp_last;
        logic [2:0] exp_srdy;
        logic [2:0] exp_done;
        logic       exp_busy;
    } vec_t;

    vec_t vecs[11];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within the time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int beats, last_beat, done_at, done_cnt, seen_done;
        logic [2:0] rq;
        logic [2:0] g;
        bit stall_mode;

        reset = 1'b1;
        bus.req = 3'b000; bus.grant = 3'b000; bus.data_in = '0; bus.out_ready = 1'b0;

        // Reset held with a grant pending: all outputs quiet.
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 3'b010, 3'b010, DATA_WORD, 1'b1);
            check("reset_outputs", pack_dut(), 32'd0);
        end

        // Idle after reset with no grant.
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 3'b000, 3'b000, DATA_WORD, 1'b1);
            check("idle_quiet", {29'd0, busy, bus.out_valid, |bus.done}, 32'd0);
        end

        // Directed client-1 burst, cycle N at index 3; grant changes mid-burst are ignored.
        //          req     grant   rdy   valid last  srdy    done    busy
        vecs[0]  = '{3'b000, 3'b000, 1'b1, 1'b0, 1'b0, 3'b000, 3'b000, 1'b0};
        vecs[1]  = '{3'b000, 3'b000, 1'b1, 1'b0, 1'b0, 3'b000, 3'b000, 1'b0};
        vecs[2]  = '{3'b000, 3'b010, 1'b1, 1'b0, 1'b0, 3'b000, 3'b000, 1'b0};
        vecs[3]  = '{3'b010, 3'b010, 1'b1, 1'b0, 1'b0, 3'b000, 3'b000, 1'b0};
        vecs[4]  = '{3'b010, 3'b000, 1'b1, 1'b1, 1'b0, 3'b010, 3'b000, 1'b1};
        vecs[5]  = '{3'b011, 3'b001, 1'b1, 1'b1, 1'b0, 3'b010, 3'b000, 1'b1};
        vecs[6]  = '{3'b010, 3'b100, 1'b1, 1'b1, 1'b0, 3'b010, 3'b000, 1'b1};
        vecs[7]  = '{3'b010, 3'b010, 1'b1, 1'b1, 1'b1, 3'b010, 3'b000, 1'b1};
        vecs[8]  = '{3'b010, 3'b010, 1'b1, 1'b0, 1'b0, 3'b000, 3'b010, 1'b1};
        vecs[9]  = '{3'b000, 3'b000, 1'b1, 1'b0, 1'b0, 3'b000, 3'b000, 1'b0};
        vecs[10] = '{3'b000, 3'b000, 1'b1, 1'b0, 1'b0, 3'b000, 3'b000, 1'b0};
        for (int i = 0; i < 11; i++) begin
            step(1'b0, vecs[i].req, vecs[i].grant, DATA_WORD, vecs[i].rdy);
            check("vec_ctrl",
                  {23'd0, bus.out_valid, bus.out_last, bus.src_ready, bus.done, busy},
                  {23'd0, vecs[i].exp_valid, vecs[i].exp_last, vecs[i].exp_srdy,
                   vecs[i].exp_done, vecs[i].exp_busy});
            if (vecs[i].exp_valid)
                check("vec_data", {22'd0, bus.out_src, bus.out_data}, {22'd0, 2'd1, 8'hA5});
        end

        // Three stalled cycles after beat 2.
        run_burst(1, 64'hFFFF_FFFF_FFFF_FFE3, beats, last_beat, done_at, done_cnt);
        check("stall_beats", 32'(beats), 32'd4);
        check("stall_last_beat", 32'(last_beat), 32'd4);
        check("stall_done_at", 32'(done_at), 32'(BURST_LEN + 1 + 3));
        check("stall_done_cnt", 32'(done_cnt), 32'd1);
        check("stall_no_timeout", {31'd0, timeout_err}, 32'd0);

        // Channel never ready: timeout after TIMEOUT stalled cycles, one done, sticky flag.
        run_burst(1, 64'd0, beats, last_beat, done_at, done_cnt);
        check("to_beats", 32'(beats), 32'd0);
        check("to_done_at", 32'(done_at), 32'(TIMEOUT + 1));
        check("to_done_cnt", 32'(done_cnt), 32'd1);
        check("to_flag_set", {30'd0, timeout_err, busy}, 32'b10);
        for (int i = 0; i < 5; i++) step(1'b0, 3'b000, 3'b000, DATA_WORD, 1'b1);
        check("to_flag_sticky", {31'd0, timeout_err}, 32'd1);
        step(1'b1, 3'b000, 3'b000, DATA_WORD, 1'b1);
        step(1'b0, 3'b000, 3'b000, DATA_WORD, 1'b1);
        check("to_flag_cleared", {31'd0, timeout_err}, 32'd0);

        // Client 0 withdraws req after its first beat, then client 2 bursts normally.
        step(1'b0, 3'b001, 3'b001, DATA_WORD, 1'b1);
        step(1'b0, 3'b001, 3'b000, DATA_WORD, 1'b1);
        check("drop_beat1", {29'd0, bus.src_ready}, 32'b001);
        step(1'b0, 3'b000, 3'b000, DATA_WORD, 1'b1);
        check("drop_no_beat", {25'd0, bus.out_valid, bus.src_ready, bus.done}, 32'd0);
        step(1'b0, 3'b000, 3'b000, DATA_WORD, 1'b1);
        check("drop_idle", {28'd0, busy, bus.done}, 32'd0);
        run_burst(2, '1, beats, last_beat, done_at, done_cnt);
        check("c2_beats", 32'(beats), 32'(BURST_LEN));
        check("c2_last_beat", 32'(last_beat), 32'(BURST_LEN));
        check("c2_done_at", 32'(done_at), 32'(BURST_LEN + 1));

        // Multi-hot grant 011 with req 011.
        step(1'b0, 3'b011, 3'b011, DATA_WORD, 1'b1);
        step(1'b0, 3'b011, 3'b000, DATA_WORD, 1'b1);
`ifdef GRANT_ONEHOT_CHK_EN
        check("mh_refused", {30'd0, grant_err, busy}, 32'b10);
`else
        check("mh_owner0", {21'd0, bus.out_valid, bus.out_src, bus.out_data},
              {21'd0, 1'b1, 2'd0, 8'h5A});
        seen_done = 0;
        for (int i = 0; i < BURST_LEN + 2; i++) begin
            step(1'b0, (seen_done != 0) ? 3'b000 : 3'b011, 3'b000, DATA_WORD, 1'b1);
            if (bus.done == 3'b001) seen_done++;
        end
        check("mh_done_client0", 32'(seen_done), 32'd1);
`endif
        step(1'b1, 3'b000, 3'b000, DATA_WORD, 1'b1);

        // Randomized run checked cycle by cycle by the model.
        rq = 3'b000;
        stall_mode = 0;
        for (int i = 0; i < 3000; i++) begin
            if (i % 250 == 0) stall_mode = ($urandom_range(0, 2) == 0);
            for (int b = 0; b < 3; b++) if ($urandom_range(0, 9) == 0) rq[b] = ~rq[b];
            case ($urandom_range(0, 7))
                0, 1, 2: g = 3'b001 << $urandom_range(0, 2);
                3:       g = rq;
                4:       g = 3'($urandom);
                default: g = 3'b000;
            endcase
            step($urandom_range(0, 299) == 0, rq, g, 24'($urandom),
                 stall_mode ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 3) != 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
